// File: rtl/iq_magnitude.sv
// Three-stage alpha-max-plus-beta-min magnitude estimator on AXI-Stream,
// with peak-hold and packet counting on the output side.
module iq_magnitude #(
    parameter int WIDTH = 16
) (
    input  logic               ce_clk,
    input  logic               ce_rst,
    input  logic               clear,
    input  logic [2*WIDTH-1:0] i_tdata,
    input  logic               i_tlast,
    input  logic               i_tvalid,
    output logic               i_tready,
    output logic [WIDTH-1:0]   o_tdata,
    output logic               o_tlast,
    output logic               o_tvalid,
    input  logic               o_tready,
    output logic [WIDTH-1:0]   peak,
    output logic [31:0]        pkt_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Handshake: a beat moves on a cycle where valid and ready are both high;
    // each stage accepts when it is empty or the stage after it is accepting.
    logic rdy1, rdy2, rdy3;

    logic             s1_valid, s1_last;
    logic [WIDTH-1:0] s1_ai, s1_aq;
    logic             s2_valid, s2_last;
    logic [WIDTH-1:0] s2_mx, s2_mn;
    logic             s3_valid, s3_last;
    logic [WIDTH-1:0] s3_mag;

    logic [WIDTH-1:0] in_i, in_q, abs_i, abs_q;
    logic [WIDTH:0]   mag_full;
    logic             out_xfer;

    assign rdy3     = ~s3_valid | o_tready;
    assign rdy2     = ~s2_valid | rdy3;
    assign rdy1     = ~s1_valid | rdy2;
    assign i_tready = rdy1 & ~ce_rst;

    assign in_i = i_tdata[2*WIDTH-1:WIDTH];
    assign in_q = i_tdata[WIDTH-1:0];

    // Two's-complement negate; the most negative input maps to 2^(WIDTH-1) exactly.
    always_comb begin
        abs_i = in_i[WIDTH-1] ? (~in_i + ONE) : in_i;
        abs_q = in_q[WIDTH-1] ? (~in_q + ONE) : in_q;
    end

    always_comb begin
        mag_full = {1'b0, s2_mx}
                 - {4'b0000, s2_mx[WIDTH-1:3]}
                 + {2'b00, s2_mn[WIDTH-1:1]};
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst || clear) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_ai    <= '0;
            s1_aq    <= '0;
        end else if (rdy1) begin
            s1_valid <= i_tvalid;
            if (i_tvalid) begin
                s1_last <= i_tlast;
                s1_ai   <= abs_i;
                s1_aq   <= abs_q;
            end
        end
    end

    // Ties keep I as the max so the ordering is deterministic.
    always_ff @(posedge ce_clk) begin
        if (ce_rst || clear) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_mx    <= '0;
            s2_mn    <= '0;
        end else if (rdy2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_mx   <= (s1_ai >= s1_aq) ? s1_ai : s1_aq;
                s2_mn   <= (s1_ai >= s1_aq) ? s1_aq : s1_ai;
            end
        end
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst || clear) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_mag   <= '0;
        end else if (rdy3) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_last <= s2_last;
                s3_mag  <= mag_full[WIDTH-1:0];
            end
        end
    end

    assign o_tdata  = s3_mag;
    assign o_tlast  = s3_last;
    assign o_tvalid = s3_valid;
    assign out_xfer = s3_valid & o_tready;

    always_ff @(posedge ce_clk) begin
        if (ce_rst || clear) begin
            peak      <= '0;
            pkt_count <= '0;
        end else if (out_xfer) begin
            if (s3_mag > peak) begin
                peak <= s3_mag;
            end
            if (s3_last) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

endmodule
